// File: rtl/byte_striping_pkg.sv
// ---------------------------------------------------------------------------
// byte_striping_pkg
//   Definitions shared by the 2-lane byte striper and its receive-side
//   unstriper:
//     DATA_W_DEF  default lane / stream word width
//     ERR_CNT_W   width of the lane-order violation counter
//     state_e     lock FSM encoding (IDLE = 0, ACTIVE = 1)
//     sat_inc     saturating increment for the error counter
// ---------------------------------------------------------------------------
package byte_striping_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ERR_CNT_W  = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

endpackage : byte_striping_pkg

// File: rtl/lane_capture.sv
// ---------------------------------------------------------------------------
// lane_capture
//   One lane's capture register: holds a word and its valid flag.
//   Ports:
//     clk_2f   in  clock, all logic on posedge
//     reset    in  synchronous, active-high
//     load     in  capture d_valid/d_word on this edge
//     clr      in  synchronous clear (lower priority than reset, higher than load)
//     d_valid  in  lane valid
//     d_word   in  lane word
//     q_valid  out captured valid
//     q_word   out captured word
// ---------------------------------------------------------------------------
module lane_capture #(
  parameter int DATA_W = 32
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              load,
  input  logic              clr,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] d_word,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_word
);

  // NOTE: registered state is always assigned with <= so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk_2f) begin
    if (reset || clr) begin
      q_valid <= 1'b0;
      q_word  <= '0;
    end else if (load) begin
      q_valid <= d_valid;
      q_word  <= d_word;
    end
  end

endmodule : lane_capture

// File: rtl/byte_unstriping.sv
// ---------------------------------------------------------------------------
// byte_unstriping
//   Merges the two striped lanes back into one DATA_W stream at clk_2f,
//   emitting the lane_0 word and then the lane_1 word of each capture.
//   Each lane presents one word per two clk_2f cycles. The first valid_0
//   seen in IDLE fixes the capture phase; it is only re-acquired after the
//   stream has been empty for IDLE_TIMEOUT capture slots (or on reset).
//
//   Parameters:
//     DATA_W        lane and output word width
//     IDLE_TIMEOUT  consecutive empty capture slots before unlocking (>= 1)
//   Ports:
//     clk_2f     in   clock, all logic on posedge
//     reset      in   synchronous, active-high
//     valid_0    in   lane_0 word valid
//     lane_0     in   lane_0 word (even stream positions)
//     valid_1    in   lane_1 word valid
//     lane_1     in   lane_1 word (odd stream positions)
//     valid_out  out  data_out valid (registered)
//     data_out   out  merged stream word, zero when not valid (registered)
//     err_cnt    out  saturating count of lane_1-without-lane_0 captures
//
//   Build option BYTE_UNSTRIPE_ERR_EN: enables the err_cnt counter.
//   Without it err_cnt is constant zero.
// ---------------------------------------------------------------------------
module byte_unstriping
  import byte_striping_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic                 clk_2f,
  input  logic                 reset,
  input  logic                 valid_0,
  input  logic [DATA_W-1:0]    lane_0,
  input  logic                 valid_1,
  input  logic [DATA_W-1:0]    lane_1,
  output logic                 valid_out,
  output logic [DATA_W-1:0]    data_out,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int TCNT_W = $clog2(IDLE_TIMEOUT + 1);

  state_e              state;
  logic                phase;
  logic [TCNT_W-1:0]   tcnt;

  logic                cap_v0, cap_v1;
  logic [DATA_W-1:0]   cap0, cap1;

  logic lock_edge;     // IDLE edge that acquires the capture phase
  logic cap_edge;      // ACTIVE phase-0 edge: emit lane_1, capture new pair
  logic load;
  logic clr;
  logic empty_slot;
  logic violation;

  assign lock_edge  = (state == IDLE) && valid_0;
  assign cap_edge   = (state == ACTIVE) && !phase;
  assign load       = lock_edge || cap_edge;
  // Keep the capture registers clean while waiting for lock.
  assign clr        = (state == IDLE) && !valid_0;
  assign empty_slot = !valid_0 && !valid_1;
  // In IDLE every edge is a candidate capture slot.
  assign violation  = valid_1 && !valid_0 && ((state == IDLE) || cap_edge);

  lane_capture #(.DATA_W(DATA_W)) u_cap_0 (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .load    (load),
    .clr     (clr),
    .d_valid (valid_0),
    .d_word  (lane_0),
    .q_valid (cap_v0),
    .q_word  (cap0)
  );

  lane_capture #(.DATA_W(DATA_W)) u_cap_1 (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .load    (load),
    .clr     (clr),
    .d_valid (valid_1),
    .d_word  (lane_1),
    .q_valid (cap_v1),
    .q_word  (cap1)
  );

  // NOTE: every control and output register has an explicit reset value so
  // a reset mid-stream leaves no stale word that could leak out afterwards.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= 1'b0;
      tcnt      <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid_out <= 1'b0;
          data_out  <= '0;
          tcnt      <= '0;
          if (valid_0) begin
            state <= ACTIVE;
            phase <= 1'b1;
          end
        end

        ACTIVE: begin
          if (phase) begin
            valid_out <= cap_v0;
            data_out  <= cap_v0 ? cap0 : '0;
            phase     <= 1'b0;
          end else begin
            // The lane_1 word goes out even on the edge that times out,
            // so nothing already captured is dropped.
            valid_out <= cap_v1;
            data_out  <= cap_v1 ? cap1 : '0;
            phase     <= 1'b1;
            if (empty_slot) begin
              if (tcnt == TCNT_W'(IDLE_TIMEOUT - 1)) begin
                state <= IDLE;
                phase <= 1'b0;
                tcnt  <= '0;
              end else begin
                tcnt <= tcnt + 1'b1;
              end
            end else begin
              tcnt <= '0;
            end
          end
        end

        default: begin
          state <= IDLE;
          phase <= 1'b0;
        end
      endcase
    end
  end

`ifdef BYTE_UNSTRIPE_ERR_EN
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (violation) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end
`else
  assign err_cnt = '0;
  logic unused_err;
  assign unused_err = violation;
`endif

endmodule : byte_unstriping
